// File: rtl/alu_mdu_unit_if.sv
// Operation bus for alu_mdu_unit: request, operands, decoded control, results and status.
interface alu_mdu_unit_if #(parameter int WIDTH = 32);
    logic [1:0]       ALUOp;
    logic [5:0]       FuncCode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             start;
    logic [3:0]       ALUCtl;
    logic [WIDTH-1:0] Result;
    logic             Zero;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             busy;
    logic             done;
    logic             DivZero;
    logic             Illegal;

    modport master (
        output ALUOp, FuncCode, A, B, start,
        input  ALUCtl, Result, Zero, HI, LO, busy, done, DivZero, Illegal
    );

    modport slave (
        input  ALUOp, FuncCode, A, B, start,
        output ALUCtl, Result, Zero, HI, LO, busy, done, DivZero, Illegal
    );
endinterface

// File: rtl/alu_mdu_unit.sv
// ALU with iterative multiply (shift-add) and divide (restoring), one step per clock.
// state | meaning
// IDLE  | waiting for start; single-cycle ops complete on the accepting edge
// MUL   | shift-add multiply, WIDTH steps
// DIV   | restoring divide, WIDTH steps
// DONE  | one-cycle completion strobe
module alu_mdu_unit #(
    parameter int WIDTH = 32
) (
    input logic           clk,
    input logic           rst_n,
    alu_mdu_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [3:0]        ctl;
    logic [2*WIDTH:0]  acc;
    logic [WIDTH-1:0]  opnd, a_hold;
    logic              neg_q, neg_r, dz_pend;
    logic [WIDTH-1:0]  result_r, hi_r, lo_r;
    logic              dz_r, ill_r;

    logic              is_mul, is_div, is_signed, a_neg, b_neg;
    logic [WIDTH-1:0]  a_mag, b_mag, single_res;
    logic [WIDTH:0]    msum, rem_sh, trial;
    logic              qbit;
    logic [2*WIDTH:0]  mul_nxt, div_nxt;
    logic [2*WIDTH-1:0] prod_fin;
    logic [WIDTH-1:0]  quo_fin, rem_fin;

    always_comb begin
        ctl = 4'b1111;
        case (bus.ALUOp)
            2'b00: ctl = 4'b0010;
            2'b01: ctl = 4'b0110;
            default: begin
                case (bus.FuncCode)
                    6'd32: ctl = 4'b0010;
                    6'd34: ctl = 4'b0110;
                    6'd36: ctl = 4'b0000;
                    6'd37: ctl = 4'b0001;
                    6'd39: ctl = 4'b1100;
                    6'd42: ctl = 4'b0111;
                    6'd24: ctl = 4'b1000;
                    6'd25: ctl = 4'b1001;
                    6'd26: ctl = 4'b1010;
                    6'd27: ctl = 4'b1011;
                    6'd16: ctl = 4'b1101;
                    6'd18: ctl = 4'b1110;
                    default: ctl = 4'b1111;
                endcase
            end
        endcase
    end

    // Iterative units work on magnitudes; the sign is re-applied on completion.
    assign is_mul    = (ctl == 4'b1000) || (ctl == 4'b1001);
    assign is_div    = (ctl == 4'b1010) || (ctl == 4'b1011);
    assign is_signed = (ctl == 4'b1000) || (ctl == 4'b1010);
    assign a_neg     = is_signed && bus.A[WIDTH-1];
    assign b_neg     = is_signed && bus.B[WIDTH-1];
    assign a_mag     = a_neg ? -bus.A : bus.A;
    assign b_mag     = b_neg ? -bus.B : bus.B;

    always_comb begin
        single_res = '0;
        case (ctl)
            4'b0010: single_res = bus.A + bus.B;
            4'b0110: single_res = bus.A - bus.B;
            4'b0000: single_res = bus.A & bus.B;
            4'b0001: single_res = bus.A | bus.B;
            4'b1100: single_res = ~(bus.A | bus.B);
            4'b0111: single_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            4'b1101: single_res = hi_r;
            4'b1110: single_res = lo_r;
            default: single_res = '0;
        endcase
    end

    assign msum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_nxt  = {1'b0, msum, acc[WIDTH-1:1]};
    assign prod_fin = neg_q ? -mul_nxt[2*WIDTH-1:0] : mul_nxt[2*WIDTH-1:0];

    assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign trial    = rem_sh - {1'b0, opnd};
    assign qbit     = ~trial[WIDTH];
    assign div_nxt  = {1'b0, (qbit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], qbit};
    assign quo_fin  = neg_q ? -div_nxt[WIDTH-1:0] : div_nxt[WIDTH-1:0];
    assign rem_fin  = neg_r ? -div_nxt[2*WIDTH-1:WIDTH] : div_nxt[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = is_mul ? MUL : (is_div ? DIV : DONE);
            MUL:  if (cnt == '0) state_nxt = DONE;
            DIV:  if (cnt == '0) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0; acc <= '0; opnd <= '0; a_hold <= '0;
            neg_q <= 1'b0; neg_r <= 1'b0; dz_pend <= 1'b0;
            result_r <= '0; hi_r <= '0; lo_r <= '0;
            dz_r <= 1'b0; ill_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    dz_r  <= 1'b0;
                    ill_r <= (ctl == 4'b1111);
                    cnt   <= CW'(WIDTH-1);
                    neg_q <= a_neg ^ b_neg;
                    neg_r <= a_neg;
                    if (is_mul) begin
                        acc  <= {{(WIDTH+1){1'b0}}, b_mag};
                        opnd <= a_mag;
                    end else if (is_div) begin
                        acc     <= {{(WIDTH+1){1'b0}}, a_mag};
                        opnd    <= b_mag;
                        a_hold  <= bus.A;
                        dz_pend <= (bus.B == '0);
                    end else begin
                        result_r <= single_res;
                    end
                end
                MUL: begin
                    acc <= mul_nxt;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        hi_r     <= prod_fin[2*WIDTH-1:WIDTH];
                        lo_r     <= prod_fin[WIDTH-1:0];
                        result_r <= prod_fin[WIDTH-1:0];
                    end
                end
                DIV: begin
                    acc <= div_nxt;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        if (dz_pend) begin
                            hi_r     <= a_hold;
                            lo_r     <= '1;
                            result_r <= '1;
                            dz_r     <= 1'b1;
                        end else begin
                            hi_r     <= rem_fin;
                            lo_r     <= quo_fin;
                            result_r <= quo_fin;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ALUCtl  = ctl;
    assign bus.Result  = result_r;
    assign bus.Zero    = (result_r == '0);
    assign bus.HI      = hi_r;
    assign bus.LO      = lo_r;
    assign bus.busy    = (state == MUL) || (state == DIV);
    assign bus.done    = (state == DONE);
    assign bus.DivZero = dz_r;
    assign bus.Illegal = ill_r;
endmodule
